fb_port_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM (320x240, 12-bit pixels) between two requesters.
  - Display read side: driven from VGA activeArea timing, one read per pixel clock.
  - Camera capture write side: bursty, stallable.
- Reads have strict priority so the display never glitches.
- Writes are buffered in a small FIFO and drained into idle RAM cycles (blanking, gaps).
- Sits between the camera capture block, the VGA pixel path and the frame-buffer RAM, all in the CLK25 domain.

---
 rtl/fb_port_arbiter_if.sv | 39 +++
 rtl/fb_port_arbiter.sv | 100 ++++++++++
 tb/tb_fb_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// Display/camera/RAM bundle for the frame-buffer port arbiter.
// The arbiter takes the slave side; requesters and RAM take the master side.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int LVL_W  = 3
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              ovf_clear;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  mem_rdata, ovf_clear,
        output rd_data, rd_valid, wr_ready,
        output mem_addr, mem_wdata, mem_we,
        output fifo_level, overflow
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output mem_rdata, ovf_clear,
        input  rd_data, rd_valid, wr_ready,
        input  mem_addr, mem_wdata, mem_we,
        input  fifo_level, overflow
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every slot,
// camera writes queue in a small FIFO and fill the idle slots.
module fb_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input logic CLK25,
    input logic reset,
    fb_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [LW-1:0]     level;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              v1;
    logic              v2;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              overflow;

    logic wr_ready;
    logic push;
    logic pop;

    // Full test uses the registered level only, so a same-cycle pop never frees a slot early
    assign wr_ready = !reset && (level != LW'(FIFO_DEPTH));
    assign push     = bus.wr_req && wr_ready;
    assign pop      = !bus.rd_req && (level != '0);

    assign bus.wr_ready   = wr_ready;
    assign bus.fifo_level = level;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_data    = rd_data;
    assign bus.overflow   = overflow;

    always_ff @(posedge CLK25) begin
        if (push) begin
            fifo_addr[wptr] <= bus.wr_addr;
            fifo_data[wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);

            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            // Stage valids track the read through address and RAM-data cycles
            v1       <= bus.rd_req;
            v2       <= v1;
            rd_valid <= v2;
            if (v2) rd_data <= bus.mem_rdata;

            mem_we <= pop;
            unique case (1'b1)
                bus.rd_req: mem_addr <= bus.rd_addr;
                pop: begin
                    mem_addr  <= fifo_addr[rptr];
                    mem_wdata <= fifo_data[rptr];
                end
                default: ;
            endcase

            if (bus.wr_req && !wr_ready)
                overflow <= 1'b1;
            else if (bus.ovf_clear)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural synchronous RAM.
module tb_fb_port_arbiter;
    logic CLK25;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [11:0] d;
        int          due;
    } rd_t;

    rd_t         rd_q[$];
    logic [28:0] wr_q[$];
    logic [11:0] ram [0:131071];

    fb_port_arbiter_if #(.ADDR_W(17), .DATA_W(12), .LVL_W(3)) bus ();

    fb_port_arbiter #(
        .ADDR_W(17), .DATA_W(12), .FIFO_DEPTH(4)
    ) dut (
        .CLK25(CLK25),
        .reset(reset),
        .bus(bus)
    );

    initial CLK25 = 1'b0;
    always #20 CLK25 = ~CLK25;
    always @(posedge CLK25) cyc <= cyc + 1;

    always @(posedge CLK25) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Monitor: pops expectations whenever the DUT presents a read or a RAM write
    always @(negedge CLK25) begin : mon
        rd_t         e;
        logic [28:0] w;
        if (bus.rd_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data %h at cycle %0d, required none",
                         bus.rd_data, cyc);
            end else begin
                e = rd_q.pop_front();
                if (bus.rd_data !== e.d || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d",
                             bus.rd_data, cyc, e.d, e.due);
                end
            end
        end
        if (bus.mem_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %0d data %h, required none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                w = wr_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== w) begin
                    errors++;
                    $display("FAIL ram_write: got addr %0d data %h, required addr %0d data %h",
                             bus.mem_addr, bus.mem_wdata, w[28:12], w[11:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK25);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int a);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'(a);
        rd_q.push_back('{12'(a), cyc + 3});
    endtask

    task automatic rd_exp(input int a, input int d);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'(a);
        rd_q.push_back('{12'(d), cyc + 3});
    endtask

    task automatic wr(input int a, input int d, input bit accept);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 17'(a);
        bus.wr_data = 12'(d);
        if (accept) wr_q.push_back({17'(a), 12'(d)});
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = 12'(i);
        reset         = 1'b1;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.ovf_clear = 1'b0;
        bus.mem_rdata = '0;

        tick();
        tick();
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_level", int'(bus.fifo_level), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_wr_ready", int'(bus.wr_ready), 0);
        reset = 1'b0;
        #1;
        chk("wr_ready_after_rst", int'(bus.wr_ready), 1);

        // Streaming reads 0..9
        for (int i = 0; i < 10; i++) begin
            rd(i);
            tick();
        end
        bus.rd_req = 1'b0;
        repeat (5) tick();

        // Three writes into idle slots
        wr(5, 12'hA, 1'b1);
        tick();
        wr(6, 12'hB, 1'b1);
        tick();
        wr(7, 12'hC, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        repeat (4) tick();
        chk("drain3_level", int'(bus.fifo_level), 0);

        // Reads hog the port while writes fill and overflow the FIFO
        for (int k = 0; k < 8; k++) begin
            rd(20 + k);
            chk("fill_wr_ready", int'(bus.wr_ready), (k < 4) ? 1 : 0);
            if (k == 5) chk("ovf_set", int'(bus.overflow), 1);
            bus.ovf_clear = (k == 5);
            if (k < 6) wr(200 + k, 12'h100 + k, k < 4);
            else bus.wr_req = 1'b0;
            tick();
        end
        bus.rd_req    = 1'b0;
        bus.ovf_clear = 1'b0;
        chk("ovf_set_wins", int'(bus.overflow), 1);
        chk("full_level", int'(bus.fifo_level), 4);
        repeat (6) tick();
        chk("drain4_level", int'(bus.fifo_level), 0);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        chk("ovf_cleared", int'(bus.overflow), 0);

        // Write-then-read of the same address
        wr(100, 12'hABC, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        tick();
        rd_exp(100, 12'hABC);
        tick();
        bus.rd_req = 1'b0;
        repeat (5) tick();

        // Reset with reads in flight and three buffered writes
        for (int k = 0; k < 3; k++) begin
            rd(30 + k);
            wr(400 + k, 12'h400 + k, 1'b1);
            tick();
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        chk("pre_rst_level", int'(bus.fifo_level), 3);
        reset = 1'b1;
        rd_q.delete();
        wr_q.delete();
        #1;
        chk("mid_rst_rd_valid", int'(bus.rd_valid), 0);
        chk("mid_rst_mem_we", int'(bus.mem_we), 0);
        chk("mid_rst_level", int'(bus.fifo_level), 0);
        chk("mid_rst_wr_ready", int'(bus.wr_ready), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();

        // Push and pop in the same cycle at level 2
        rd(40);
        wr(300, 12'h300, 1'b1);
        tick();
        rd(41);
        wr(301, 12'h301, 1'b1);
        tick();
        chk("lvl2_before", int'(bus.fifo_level), 2);
        bus.rd_req = 1'b0;
        wr(302, 12'h302, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        chk("lvl2_pushpop", int'(bus.fifo_level), 2);
        repeat (6) tick();
        chk("final_level", int'(bus.fifo_level), 0);

        repeat (4) tick();
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
